lsu_align_ctrl: RTL and testbench

//  Load/store alignment controller between the EX/MEM address stage and a synchronous word-wide data RAM.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane_shift.sv | 44 ++++
 rtl/lsu_align_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment controller.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size, funct3[1:0]
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_LO   = 3'd2,
        LD_HI   = 3'd3,
        ST_HI   = 3'd4
    } lsu_state_t;

    // Right-justified byte mask for an access size; illegal size gives no bytes.
    function automatic logic [3:0] byte_mask(input logic [1:0] size);
        case (size)
            SZ_B:    byte_mask = 4'b0001;
            SZ_H:    byte_mask = 4'b0011;
            SZ_W:    byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Lane steering: 8-bit byte-enable window, store lane shift, 64-bit load funnel shift.
// Latency: purely combinational.
// Backpressure: none; the controller decides when results are used.
//
// Ports:
//  req_size/req_off : size and byte offset of the incoming request (store + enable path)
//  st_data          : right-justified store data
//  ld_size/ld_off   : size and offset latched for the load in flight
//  ld_lo/ld_hi      : lower / upper RAM word feeding the funnel shifter
//  be8              : byte enables across two consecutive words ([3:0] word A, [7:4] word A+1)
//  st_lanes         : store data shifted into lane position across the two words
//  ld_data          : right-justified load data, bytes beyond the access size cleared
//  misaligned       : access crosses into the next word
module lsu_lane_shift
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [7:0]  be8,
    output logic [63:0] st_lanes,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [63:0] funnel;
    logic [3:0]  ld_mask;

    always_comb begin
        be8        = {4'b0000, byte_mask(req_size)} << req_off;
        st_lanes   = {32'h0, st_data} << {req_off, 3'b000};
        funnel     = {ld_hi, ld_lo} >> {ld_off, 3'b000};
        ld_mask    = byte_mask(ld_size);
        ld_data    = funnel[31:0] & {{8{ld_mask[3]}}, {8{ld_mask[2]}},
                                     {8{ld_mask[1]}}, {8{ld_mask[0]}}};
        // Any enable landing in the upper word means the access spills over.
        misaligned = |be8[7:4];
    end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller between EX/MEM and a word-wide synchronous data RAM.
// Latency: aligned store 0 stall, aligned load 1 cycle, misaligned load 2 cycles, misaligned store 1 stall.
// Backpressure: req_ready is high only in IDLE; a multi-cycle access holds the pipeline off.
//
// Ports:
//  clk, rst                      : clock, synchronous active-high reset
//  req_valid/req_ready           : request handshake; req_we, req_addr, req_wdata, funct3 qualify it
//  rsp_valid/ld_data_tmp/ld_funct3 : load result pulse, right-justified raw data, its funct3
//  access_err                    : one-cycle pulse after accepting an illegal/unsupported access
//  mem_addr/mem_we/mem_re/mem_be/mem_wdata/mem_rdata : data RAM port (read data one cycle after mem_re)
module lsu_align_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [31:0]                    req_addr,
    input  logic [31:0]                    req_wdata,
    input  logic [2:0]                     funct3,
    output logic                           req_ready,
    output logic                           rsp_valid,
    output logic [31:0]                    ld_data_tmp,
    output logic [2:0]                     ld_funct3,
    output logic                           access_err,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic                           mem_we,
    output logic                           mem_re,
    output logic [3:0]                     mem_be,
    output logic [31:0]                    mem_wdata,
    input  logic [31:0]                    mem_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    lsu_state_t    state;
    logic [AW-1:0] word_q;
    logic [AW-1:0] word_plus1;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic [2:0]    f3_q;
    logic [31:0]   lo_q;
    logic [31:0]   st_hi_q;
    logic [3:0]    be_hi_q;
    logic          err_q;
    logic [31:0]   ld_data_q;
    logic [2:0]    ld_funct3_q;

    logic [31:0]   word_full;
    logic [AW-1:0] req_word;
    logic [1:0]    req_size;
    logic [1:0]    req_off;
    logic          accept;
    logic          req_err;
    logic [7:0]    be8;
    logic [63:0]   st_lanes;
    logic [31:0]   ld_data;
    logic          misaligned;
    logic [31:0]   funnel_lo;
    logic [31:0]   funnel_hi;

    assign req_size  = funct3[1:0];
    assign req_off   = req_addr[1:0];
    assign word_full = (req_addr >> 2) % DEPTH_WORDS;
    assign req_word  = word_full[AW-1:0];
    assign word_plus1 = (word_q == AW'(DEPTH_WORDS - 1)) ? '0 : word_q + 1'b1;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready & ~rst;
    assign req_err   = (req_size == SZ_ILL) | (misaligned & ~MISALIGN_EN);

    // Aligned loads funnel a single word; the split path pairs the latched low word
    // with the second read.
    assign funnel_lo = (state == LD_HI) ? lo_q : mem_rdata;
    assign funnel_hi = (state == LD_HI) ? mem_rdata : 32'h0;

    lsu_lane_shift u_lane_shift (
        .req_size   (req_size),
        .req_off    (req_off),
        .st_data    (req_wdata),
        .ld_size    (size_q),
        .ld_off     (off_q),
        .ld_lo      (funnel_lo),
        .ld_hi      (funnel_hi),
        .be8        (be8),
        .st_lanes   (st_lanes),
        .ld_data    (ld_data),
        .misaligned (misaligned)
    );

    // RAM port is driven combinationally so the first access issues in the accept cycle.
    // Reset suppresses every strobe so a dropped access never touches the RAM.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        mem_addr  = word_q;
        case (state)
            IDLE: begin
                mem_addr = req_word;
                if (req_valid && !rst && !req_err) begin
                    if (req_we) begin
                        mem_we    = 1'b1;
                        mem_be    = be8[3:0];
                        mem_wdata = st_lanes[31:0];
                    end else begin
                        mem_re = 1'b1;
                    end
                end
            end
            LD_LO: begin
                mem_addr = word_plus1;
                mem_re   = ~rst;
            end
            ST_HI: begin
                mem_addr  = word_plus1;
                mem_we    = ~rst;
                mem_be    = rst ? 4'b0000 : be_hi_q;
                mem_wdata = st_hi_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_q      <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            f3_q        <= 3'b000;
            lo_q        <= 32'h0;
            st_hi_q     <= 32'h0;
            be_hi_q     <= 4'b0000;
            err_q       <= 1'b0;
            ld_data_q   <= 32'h0;
            ld_funct3_q <= 3'b000;
        end else begin
            err_q <= accept & req_err;
            case (state)
                IDLE: begin
                    if (accept && !req_err) begin
                        word_q <= req_word;
                        off_q  <= req_off;
                        size_q <= req_size;
                        if (req_we) begin
                            if (misaligned) begin
                                st_hi_q <= st_lanes[63:32];
                                be_hi_q <= be8[7:4];
                                state   <= ST_HI;
                            end
                        end else begin
                            f3_q  <= funct3;
                            state <= misaligned ? LD_LO : LD_WAIT;
                        end
                    end
                end
                LD_LO: begin
                    lo_q  <= mem_rdata;
                    state <= LD_HI;
                end
                LD_WAIT, LD_HI: begin
                    ld_data_q   <= ld_data;
                    ld_funct3_q <= f3_q;
                    state       <= IDLE;
                end
                ST_HI:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The response is presented straight from the RAM read in its cycle and then
    // held in the *_q copies so the outputs stay stable between responses.
    assign rsp_valid   = ~rst & ((state == LD_WAIT) | (state == LD_HI));
    assign ld_data_tmp = rsp_valid ? ld_data : ld_data_q;
    assign ld_funct3   = rsp_valid ? f3_q : ld_funct3_q;
    assign access_err  = err_q;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Scoreboard bench: byte-level reference memory, queued expected responses and errors.
// Latency: n/a.
// Backpressure: stimulus waits on req_ready of the main instance.
module tb_lsu_align_ctrl;
    import lsu_pkg::*;

    localparam int DW = 2048;
    localparam int NB = 4 * DW;
    localparam int AW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic [2:0]    funct3 = 3'b000;

    logic          req_ready, rsp_valid, access_err, mem_we, mem_re;
    logic [31:0]   ld_data_tmp, mem_wdata, mem_rdata;
    logic [2:0]    ld_funct3;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    logic          req_ready_2, rsp_valid_2, access_err_2, mem_we_2, mem_re_2;
    logic [31:0]   ld_data_tmp_2, mem_wdata_2;
    logic [31:0]   mem_rdata_2 = 32'h0;
    logic [2:0]    ld_funct3_2;
    logic [AW-1:0] mem_addr_2;
    logic [3:0]    mem_be_2;

    lsu_align_ctrl #(.DEPTH_WORDS(DW), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .funct3(funct3), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .ld_data_tmp(ld_data_tmp), .ld_funct3(ld_funct3), .access_err(access_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_align_ctrl #(.DEPTH_WORDS(DW), .MISALIGN_EN(1'b0)) dut_nomis (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .funct3(funct3), .req_ready(req_ready_2), .rsp_valid(rsp_valid_2),
        .ld_data_tmp(ld_data_tmp_2), .ld_funct3(ld_funct3_2), .access_err(access_err_2),
        .mem_addr(mem_addr_2), .mem_we(mem_we_2), .mem_re(mem_re_2), .mem_be(mem_be_2),
        .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata_2)
    );

    // RAM model attached to the main instance
    logic [31:0] ram [DW];
    logic [31:0] rdata_r = 32'h0;
    assign mem_rdata = rdata_r;
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_re) rdata_r <= ram[mem_addr];
    end

    // Reference: flat byte memory, wrapping modulo its size
    logic [7:0] ref_b [NB];

    typedef struct { logic [31:0] data; logic [2:0] f3; } rsp_t;
    rsp_t rsp_q[$];
    bit   err1_q[$];
    bit   err2_q[$];

    int vec_cnt = 0;
    int mis_cnt = 0;

    // Snapshot of the RAM port in the accept cycle of the last issue
    logic          acc_we, acc_re;
    logic [AW-1:0] acc_addr;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vec_cnt++;
        mis_cnt++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitors
    logic acc1_d = 1'b0;
    logic acc2_d = 1'b0;
    always @(posedge clk) begin
        acc1_d <= req_valid && req_ready && !rst;
        acc2_d <= req_valid && req_ready_2 && !rst;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) fail_now("rsp_unexpected");
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("ld_data_tmp", ld_data_tmp, e.data);
                    check("ld_funct3", ld_funct3, e.f3);
                end
            end
            if (mem_we && mem_re) fail_now("we_re_same_cycle");
            if (acc1_d) begin
                if (err1_q.size() == 0) fail_now("err_q_underflow");
                else check("access_err", access_err, err1_q.pop_front());
            end else if (access_err) fail_now("access_err_spurious");
            if (acc2_d) begin
                if (err2_q.size() == 0) fail_now("err2_q_underflow");
                else check("access_err_nomis", access_err_2, err2_q.pop_front());
            end
        end
    end

    task automatic set_word(input int w, input logic [31:0] v);
        ram[w] = v;
        for (int b = 0; b < 4; b++) ref_b[4*w + b] = v[8*b +: 8];
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3);
        int n, off, guard;
        bit ill, mis;
        logic [31:0] d;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            fail_now("ready_timeout");
            return;
        end
        ill = (f3[1:0] == 2'b11);
        n   = ill ? 0 : (1 << f3[1:0]);
        off = int'(addr[1:0]);
        mis = !ill && (off + n > 4);
        if (!ill) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_b[(addr + i) % NB] = wdata[8*i +: 8];
            end else begin
                d = 32'h0;
                for (int i = 0; i < n; i++) d[8*i +: 8] = ref_b[(addr + i) % NB];
                rsp_q.push_back('{d, f3});
            end
        end
        err1_q.push_back(ill);
        err2_q.push_back(ill || mis);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        funct3    = f3;
        #1;
        acc_we = mem_we; acc_re = mem_re; acc_addr = mem_addr;
        acc_be = mem_be; acc_wdata = mem_wdata;
        if (ill) check("no_strobe_illegal", {mem_we, mem_re}, 2'b00);
        if (ill || mis) check("no_strobe_nomis", {mem_we_2, mem_re_2}, 2'b00);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    logic [2:0] ld_f3s [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    logic [2:0] st_f3s [3] = '{F3_SB, F3_SH, F3_SW};

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          guard;

        for (int w = 0; w < DW; w++) set_word(w, $urandom());

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_outputs", {rsp_valid, access_err, mem_we, mem_re, mem_be}, 8'h00);
        check("rst_ld_data", {ld_data_tmp, ld_funct3}, 35'h0);

        // Aligned word load
        set_word(32'h40, 32'hDEADBEEF);
        issue(1'b0, 32'h100, 32'h0, F3_LW);
        check("lw_accept_port", {acc_re, acc_we, 5'h0, acc_addr}, {2'b10, 5'h0, 11'h040});
        check("lw_rsp_next_cycle", rsp_valid, 1'b1);

        // Byte load at top lane, one stall
        set_word(32'h40, 32'h11223344);
        issue(1'b0, 32'h103, 32'h0, F3_LBU);
        check("lbu_stall", req_ready, 1'b0);
        @(posedge clk); #1;
        check("lbu_ready_again", req_ready, 1'b1);

        // Misaligned word load
        set_word(32'h40, 32'h44332211);
        set_word(32'h41, 32'h88776655);
        issue(1'b0, 32'h102, 32'h0, F3_LW);
        check("lw_mis_first_read", {acc_re, 5'h0, acc_addr}, {1'b1, 5'h0, 11'h040});
        check("lw_mis_second_read", {mem_re, rsp_valid, 4'h0, mem_addr}, {2'b10, 4'h0, 11'h041});
        @(posedge clk); #1;
        check("lw_mis_rsp", rsp_valid, 1'b1);

        // Misaligned halfword store
        issue(1'b1, 32'h103, 32'h0000ABCD, F3_SH);
        check("sh_lo_port", {acc_we, acc_be, acc_wdata[31:24], 5'h0, acc_addr},
              {1'b1, 4'b1000, 8'hCD, 5'h0, 11'h040});
        check("sh_hi_port", {mem_we, mem_be, mem_wdata[7:0], 5'h0, mem_addr},
              {1'b1, 4'b0001, 8'hAB, 5'h0, 11'h041});
        check("sh_stall", req_ready, 1'b0);
        @(posedge clk); #1;
        check("sh_ready_again", req_ready, 1'b1);

        // Word load wrapping from the top word to word 0
        issue(1'b0, NB - 2, 32'h0, F3_LW);
        check("wrap_second_read", {mem_re, 5'h0, mem_addr}, {1'b1, 5'h0, 11'h000});

        // Reset while in LD_HI drops the access
        issue(1'b0, 32'h102, 32'h0, F3_LW);
        @(posedge clk); #1;
        rsp_q.pop_back();
        rst = 1'b1;
        #1;
        check("rst_ldhi_quiet", {rsp_valid, mem_re, mem_we}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ldhi_ready", req_ready, 1'b1);
        check("rst_ldhi_no_rsp", rsp_valid, 1'b0);

        // Illegal size
        issue(1'b0, 32'h100, 32'h0, 3'b011);
        check("illegal_err_pulse", access_err, 1'b1);

        // Misaligned halfword with splitting disabled
        issue(1'b0, 32'h103, 32'h0, F3_LH);
        check("nomis_err_pulse", access_err_2, 1'b1);
        @(posedge clk); #1;

        // Randomised traffic near a low window and around the wrap point
        for (int it = 0; it < 400; it++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) f3 = we ? 3'b011 : 3'b111;
            else f3 = we ? st_f3s[$urandom_range(0, 2)] : ld_f3s[$urandom_range(0, 4)];
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[12:0] = 13'(32'h100 + $urandom_range(0, 71));
            else a[12:0] = 13'(NB - 36 + $urandom_range(0, 35));
            issue(we, a, $urandom(), f3);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        guard = 0;
        while ((rsp_q.size() != 0 || !req_ready) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rsp_q_drained", rsp_q.size(), 0);
        check("err_q_drained", err1_q.size() + err2_q.size(), 0);
        for (int w = 0; w < DW; w++)
            check("ram_contents", ram[w],
                  {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
